regfile_fw: RTL
===============

Name: regfile_fw

Overview:
- Responder side of the decode stage's operand interface. It answers the two register read requests from decode with read data.
- It also drives the forwarding controls (fw_en1/2, fw_data1/2) that decode uses to override operands.
- It holds the 32x32 integer register file, written from write-back.
- It keeps a busy scoreboard for long-latency M-extension divide results and raises a pipeline stall on load-use or busy-source hazards.

Parameters:
- RDATA_WIDTH, 32, register data width
- RADDR_WIDTH, 5, register address width
- REG_NUM, 32, number of architectural registers (x0 hard-wired zero)

Ports:
- clk_i  in  1  clock, all state updates on rising edge
- rst_i  in  1  reset, synchronous, active-high
- reg1_raddr_i  in  RADDR_WIDTH  source-1 address from decode
- reg1_re_i  in  1  source-1 read enable
- reg2_raddr_i  in  RADDR_WIDTH  source-2 address from decode
- reg2_re_i  in  1  source-2 read enable
- reg1_rdata_o  out  RDATA_WIDTH  source-1 array data
- reg2_rdata_o  out  RDATA_WIDTH  source-2 array data
- fw_en1_o  out  1  source-1 forwarding override valid
- fw_en2_o  out  1  source-2 forwarding override valid
- fw_data1_o  out  RDATA_WIDTH  source-1 forwarded value
- fw_data2_o  out  RDATA_WIDTH  source-2 forwarded value
- exe_we_i  in  1  EXE-stage instruction writes rd
- exe_waddr_i  in  RADDR_WIDTH  EXE rd
- exe_wdata_i  in  RDATA_WIDTH  EXE ALU result
- exe_is_load_i  in  1  EXE instruction is a load (data not yet available)
- mem_we_i  in  1  MEM-stage write enable
- mem_waddr_i  in  RADDR_WIDTH  MEM rd
- mem_wdata_i  in  RDATA_WIDTH  MEM result
- wb_we_i  in  1  write-back enable
- wb_waddr_i  in  RADDR_WIDTH  write-back rd
- wb_wdata_i  in  RDATA_WIDTH  write-back data
- div_issue_i  in  1  divide/remainder issued this cycle
- div_waddr_i  in  RADDR_WIDTH  divide destination
- div_done_i  in  1  divide result completes (arrives via wb port this cycle)
- div_done_waddr_i  in  RADDR_WIDTH  completing divide destination
- stall_o  out  1  freeze fetch/decode, bubble into EXE
- stall_cnt_o  out  32  saturating count of stalled cycles

Behaviour:
- Reset (rst_i high at edge):
  - All array entries, all busy bits and stall_cnt_o cleared.
  - While rst_i is high, the combinational outputs read 0: rdata, fw_en, fw_data, stall_o.
- Array write: on the edge, if wb_we_i and wb_waddr_i != 0, then regs[wb_waddr_i] <= wb_wdata_i. Writes to x0 are dropped.
- Array read: combinational, zero latency.
  - regN_rdata_o = regs[addr] when regN_re_i is high and addr != 0, else 0.
  - No internal write-through; the WB bypass goes through the fw path.
- Forwarding (per source N): active only when regN_re_i is high and addr != 0.
  - Priority EXE > MEM > WB, youngest wins.
  - EXE match (exe_we_i, exe_waddr_i == addr, !exe_is_load_i): fw_en=1, fw_data=exe_wdata_i.
  - Else MEM match: fw_en=1, fw_data=mem_wdata_i.
  - Else WB match: fw_en=1, fw_data=wb_wdata_i.
  - Else fw_en=0, fw_data=0.
- Load-use: if EXE matches a source and exe_is_load_i is high, stall_o=1 and fw_en for that source is 0.
  - Older MEM/WB matches are not used.
- Scoreboard: busy[31:0] register.
  - div_issue_i sets busy[div_waddr_i].
  - div_done_i clears busy[div_done_waddr_i].
  - Set and clear of the same register in the same cycle: set wins.
  - busy[0] is never set.
  - A read hitting a busy register raises stall_o, except on the cycle div_done_i completes that register; then the WB forward supplies the data and there is no stall.
- stall_o = load-use hazard OR busy hazard on either enabled source.
- stall_cnt_o increments on each edge with stall_o=1 and saturates at 0xFFFFFFFF.
- Reset mid-operation: busy bits and counter are cleared; in-flight divide completions after reset only write the array.

Decomposition:
- Shared defines header (existing): RADDR_WIDTH, RDATA_WIDTH, ZERO_REG, ZERO, READ/WRITE_ENABLE/DISABLE.
- Add REG_NUM and STALL_CNT_MAX to it.
- One sub-module fw_sel, instantiated twice: per-source priority mux plus load-use/busy hazard flag. Array, scoreboard and counter stay in the top.

Test Plan:
- Reset then read x5 -> rdata 0, fw_en 0, stall_o 0. Write x0=0xDEAD via WB, read x0 -> 0.
- WB x3=0x11 (cycle 0); read x3 at cycle 0 -> fw_en1=1, fw_data1=0x11. Read at cycle 1 -> fw_en1=0, rdata 0x11.
- EXE x4=0xA, MEM x4=0xB, WB x4=0xC together, read x4 on both sources -> fw_data1/2=0xA.
- EXE load to x7, decode reads x7 via source 2 -> stall_o=1, fw_en2=0, stall_cnt 0->1. Next cycle the load moves to MEM -> fw_data2=mem_wdata_i, no stall.
- div_issue x9; reads of x9 stall 3 cycles; div_done x9 with wb x9=0x42 -> stall_o=0, fw_data=0x42. Same-cycle issue/done on x9 -> busy stays 1.
- Busy x9, assert rst_i for one cycle -> busy cleared, stall_cnt 0, read x9 no stall.

Source files
------------

// File: rtl/regfile_fw_pkg.sv
// regfile_fw_pkg: shared widths, enables and forwarding-source encoding for the operand responder
package regfile_fw_pkg;
  localparam int RADDR_WIDTH = 5;
  localparam int RDATA_WIDTH = 32;
  localparam int REG_NUM = 32;
  localparam logic [RADDR_WIDTH-1:0] ZERO_REG = '0;
  localparam logic [RDATA_WIDTH-1:0] ZERO = '0;
  localparam logic READ_ENABLE = 1'b1;
  localparam logic READ_DISABLE = 1'b0;
  localparam logic WRITE_ENABLE = 1'b1;
  localparam logic WRITE_DISABLE = 1'b0;
  localparam logic [31:0] STALL_CNT_MAX = 32'hFFFF_FFFF;
  typedef enum logic [1:0] {SRC_NONE, SRC_WB, SRC_MEM, SRC_EXE} fw_src_e;
endpackage

// File: rtl/regfile_fw_fw_sel.sv
// fw_sel: per-source EXE>MEM>WB forwarding mux with load-use and busy-register hazard flag
module fw_sel
  import regfile_fw_pkg::*;
#(
  parameter int RDATA_WIDTH = 32,
  parameter int RADDR_WIDTH = 5,
  parameter int REG_NUM = 32
) (
  input  logic                   re,
  input  logic [RADDR_WIDTH-1:0] addr,
  input  logic                   exe_we,
  input  logic [RADDR_WIDTH-1:0] exe_waddr,
  input  logic [RDATA_WIDTH-1:0] exe_wdata,
  input  logic                   exe_is_load,
  input  logic                   mem_we,
  input  logic [RADDR_WIDTH-1:0] mem_waddr,
  input  logic [RDATA_WIDTH-1:0] mem_wdata,
  input  logic                   wb_we,
  input  logic [RADDR_WIDTH-1:0] wb_waddr,
  input  logic [RDATA_WIDTH-1:0] wb_wdata,
  input  logic [REG_NUM-1:0]     busy,
  input  logic                   div_done,
  input  logic [RADDR_WIDTH-1:0] div_done_waddr,
  output logic                   fw_en,
  output logic [RDATA_WIDTH-1:0] fw_data,
  output logic                   hazard
);
  logic act, exe_hit, mem_hit, wb_hit, load_use, busy_hit;
  fw_src_e src;
  assign act = re == READ_ENABLE && addr != '0;
  assign exe_hit = act && exe_we && exe_waddr == addr;
  assign mem_hit = act && mem_we && mem_waddr == addr;
  assign wb_hit = act && wb_we && wb_waddr == addr;
  assign load_use = exe_hit && exe_is_load;
  // a pending load in EXE shadows older MEM/WB copies of the same register
  assign src = exe_hit ? (exe_is_load ? SRC_NONE : SRC_EXE) :
               mem_hit ? SRC_MEM : wb_hit ? SRC_WB : SRC_NONE;
  assign fw_en = src != SRC_NONE;
  assign fw_data = src == SRC_EXE ? exe_wdata : src == SRC_MEM ? mem_wdata :
                   src == SRC_WB ? wb_wdata : '0;
  // the completing divide's result arrives on the WB forward, so no stall that cycle
  assign busy_hit = act && busy[addr] && !(div_done && div_done_waddr == addr);
  assign hazard = load_use || busy_hit;
endmodule

// File: rtl/regfile_fw.sv
// regfile_fw: 32x32 register file with operand forwarding, divide scoreboard and stall generation
module regfile_fw
  import regfile_fw_pkg::*;
#(
  parameter int RDATA_WIDTH = 32,
  parameter int RADDR_WIDTH = 5,
  parameter int REG_NUM = 32
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [RADDR_WIDTH-1:0] reg1_raddr_i,
  input  logic                   reg1_re_i,
  input  logic [RADDR_WIDTH-1:0] reg2_raddr_i,
  input  logic                   reg2_re_i,
  output logic [RDATA_WIDTH-1:0] reg1_rdata_o,
  output logic [RDATA_WIDTH-1:0] reg2_rdata_o,
  output logic                   fw_en1_o,
  output logic                   fw_en2_o,
  output logic [RDATA_WIDTH-1:0] fw_data1_o,
  output logic [RDATA_WIDTH-1:0] fw_data2_o,
  input  logic                   exe_we_i,
  input  logic [RADDR_WIDTH-1:0] exe_waddr_i,
  input  logic [RDATA_WIDTH-1:0] exe_wdata_i,
  input  logic                   exe_is_load_i,
  input  logic                   mem_we_i,
  input  logic [RADDR_WIDTH-1:0] mem_waddr_i,
  input  logic [RDATA_WIDTH-1:0] mem_wdata_i,
  input  logic                   wb_we_i,
  input  logic [RADDR_WIDTH-1:0] wb_waddr_i,
  input  logic [RDATA_WIDTH-1:0] wb_wdata_i,
  input  logic                   div_issue_i,
  input  logic [RADDR_WIDTH-1:0] div_waddr_i,
  input  logic                   div_done_i,
  input  logic [RADDR_WIDTH-1:0] div_done_waddr_i,
  output logic                   stall_o,
  output logic [31:0]            stall_cnt_o
);
  logic [RDATA_WIDTH-1:0] regs [REG_NUM];
  logic [REG_NUM-1:0] busy, busy_nxt;
  logic en1, en2, haz1, haz2;
  logic [RDATA_WIDTH-1:0] d1, d2;
  fw_sel #(.RDATA_WIDTH(RDATA_WIDTH), .RADDR_WIDTH(RADDR_WIDTH), .REG_NUM(REG_NUM)) u_fw1 (
    .re(reg1_re_i), .addr(reg1_raddr_i),
    .exe_we(exe_we_i), .exe_waddr(exe_waddr_i), .exe_wdata(exe_wdata_i), .exe_is_load(exe_is_load_i),
    .mem_we(mem_we_i), .mem_waddr(mem_waddr_i), .mem_wdata(mem_wdata_i),
    .wb_we(wb_we_i), .wb_waddr(wb_waddr_i), .wb_wdata(wb_wdata_i),
    .busy(busy), .div_done(div_done_i), .div_done_waddr(div_done_waddr_i),
    .fw_en(en1), .fw_data(d1), .hazard(haz1)
  );
  fw_sel #(.RDATA_WIDTH(RDATA_WIDTH), .RADDR_WIDTH(RADDR_WIDTH), .REG_NUM(REG_NUM)) u_fw2 (
    .re(reg2_re_i), .addr(reg2_raddr_i),
    .exe_we(exe_we_i), .exe_waddr(exe_waddr_i), .exe_wdata(exe_wdata_i), .exe_is_load(exe_is_load_i),
    .mem_we(mem_we_i), .mem_waddr(mem_waddr_i), .mem_wdata(mem_wdata_i),
    .wb_we(wb_we_i), .wb_waddr(wb_waddr_i), .wb_wdata(wb_wdata_i),
    .busy(busy), .div_done(div_done_i), .div_done_waddr(div_done_waddr_i),
    .fw_en(en2), .fw_data(d2), .hazard(haz2)
  );
  assign reg1_rdata_o = (!rst_i && reg1_re_i == READ_ENABLE && reg1_raddr_i != '0) ? regs[reg1_raddr_i] : '0;
  assign reg2_rdata_o = (!rst_i && reg2_re_i == READ_ENABLE && reg2_raddr_i != '0) ? regs[reg2_raddr_i] : '0;
  assign fw_en1_o = !rst_i && en1;
  assign fw_en2_o = !rst_i && en2;
  assign fw_data1_o = rst_i ? '0 : d1;
  assign fw_data2_o = rst_i ? '0 : d2;
  assign stall_o = !rst_i && (haz1 || haz2);
  // issue is applied after completion so a same-register set/clear keeps the bit set
  always_comb begin
    busy_nxt = busy;
    if (div_done_i) busy_nxt[div_done_waddr_i] = 1'b0;
    if (div_issue_i && div_waddr_i != '0) busy_nxt[div_waddr_i] = 1'b1;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < REG_NUM; i++) regs[i] <= '0;
      busy <= '0;
      stall_cnt_o <= '0;
    end else begin
      if (wb_we_i == WRITE_ENABLE && wb_waddr_i != '0) regs[wb_waddr_i] <= wb_wdata_i;
      busy <= busy_nxt;
      if (stall_o && stall_cnt_o != STALL_CNT_MAX) stall_cnt_o <= stall_cnt_o + 32'd1;
    end
  end
endmodule
